// File: rtl/serial_link_master.sv
// rtl/serial_link_master.sv - board-side sequencer for the 4-slot serial register bridge (optional LINK_AUTORUN_EN adds auto_run)
module serial_link_master #(
  parameter int SLOTS  = 4,
  parameter int WORD_W = 32,
  parameter int DIV_W  = 8,
  localparam int SLOT_W = $clog2(SLOTS),
  localparam int BIT_W  = $clog2(WORD_W)
) (
  input  logic              clk_board,
  input  logic              sys_reset_n,
  input  logic              start,
  input  logic [DIV_W-1:0]  div,
  input  logic              tx_wr_en,
  input  logic [SLOT_W-1:0] tx_wr_slot,
  input  logic [WORD_W-1:0] tx_wr_data,
  input  logic [SLOT_W-1:0] rx_rd_slot,
  output logic [WORD_W-1:0] rx_rd_data,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_cnt,
  output logic              link_clk,
  output logic              link_sync_en,
  output logic              link_dout,
  input  logic              link_din
`ifdef LINK_AUTORUN_EN
  ,
  input  logic              auto_run
`endif
);

  typedef enum logic [2:0] {IDLE, SYNC, SHIFT, COMMIT, FINISH} state_t;

  localparam logic [SLOT_W-1:0] LAST_WIN = SLOT_W'(SLOTS - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(WORD_W - 1);

  state_t                         state;
  logic [SLOTS-1:0][WORD_W-1:0]   tx_buf;
  logic [SLOTS-1:0][WORD_W-1:0]   tx_shadow;
  logic [SLOTS-1:0][WORD_W-1:0]   rx_shadow;
  logic [SLOTS-1:0][WORD_W-1:0]   rx_buf;
  logic [DIV_W-1:0]               div_q;
  logic [DIV_W-1:0]               div_cnt;
  logic [BIT_W-1:0]               bit_cnt;
  logic [SLOT_W-1:0]              win_cnt;
  logic [BIT_W-1:0]               next_bit;
  logic [SLOT_W-1:0]              nxt_slot;
  logic                           chain;

`ifdef LINK_AUTORUN_EN
  assign chain = auto_run;
`else
  assign chain = 1'b0;
`endif

  // The peripheral advances its slot only after a full word, so window s carries slot s+1.
  assign nxt_slot   = win_cnt + 1'b1;
  assign next_bit   = bit_cnt + 1'b1;
  assign rx_rd_data = rx_buf[rx_rd_slot];

  // Board-side tx staging buffer, writable at any time.
  always_ff @(posedge clk_board or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      tx_buf <= '0;
    end else if (tx_wr_en) begin
      tx_buf[tx_wr_slot] <= tx_wr_data;
    end
  end

  // Frame sequencer: link clock divider, framing, shift-out and sample-in.
  always_ff @(posedge clk_board or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      frame_cnt    <= '0;
      link_clk     <= 1'b0;
      link_sync_en <= 1'b0;
      link_dout    <= 1'b0;
      tx_shadow    <= '0;
      rx_shadow    <= '0;
      rx_buf       <= '0;
      div_q        <= '0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      win_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state        <= SYNC;
            busy         <= 1'b1;
            tx_shadow    <= tx_buf;
            div_q        <= div;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            win_cnt      <= '0;
            link_clk     <= 1'b0;
            link_sync_en <= 1'b1;
            link_dout    <= 1'b0;
          end
        end
        FINISH: begin
          done <= 1'b0;
          // A chained frame uses this cycle as the first low cycle of its leading SYNC.
          if (busy) begin
            state <= SYNC;
            if (div_cnt == div_q) begin
              div_cnt  <= '0;
              link_clk <= 1'b1;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          if (div_cnt != div_q) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!link_clk) begin
              link_clk <= 1'b1;
            end else begin
              // Last cycle of the high phase: sample link_din and set up the next period.
              link_clk <= 1'b0;
              case (state)
                SYNC: begin
                  rx_shadow[win_cnt][0] <= link_din;
                  state        <= SHIFT;
                  bit_cnt      <= '0;
                  link_sync_en <= 1'b0;
                  link_dout    <= tx_shadow[nxt_slot][0];
                end
                SHIFT: begin
                  if (bit_cnt != LAST_BIT) begin
                    rx_shadow[win_cnt][next_bit] <= link_din;
                    bit_cnt   <= next_bit;
                    link_dout <= tx_shadow[nxt_slot][next_bit];
                  end else begin
                    bit_cnt      <= '0;
                    link_dout    <= 1'b0;
                    link_sync_en <= 1'b1;
                    if (win_cnt != LAST_WIN) begin
                      win_cnt <= win_cnt + 1'b1;
                      state   <= SYNC;
                    end else begin
                      win_cnt <= '0;
                      state   <= COMMIT;
                    end
                  end
                end
                default: begin
                  state     <= FINISH;
                  done      <= 1'b1;
                  rx_buf    <= rx_shadow;
                  frame_cnt <= frame_cnt + 1'b1;
                  link_dout <= 1'b0;
                  if (chain) begin
                    busy         <= 1'b1;
                    tx_shadow    <= tx_buf;
                    div_q        <= div;
                    link_sync_en <= 1'b1;
                  end else begin
                    busy         <= 1'b0;
                    link_sync_en <= 1'b0;
                  end
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_link_master.sv
// tb/tb_serial_link_master.sv - scoreboard bench for serial_link_master with a peripheral loopback model
module tb_serial_link_master;

  logic        clk_board = 1'b0;
  logic        sys_reset_n;
  logic        start;
  logic [7:0]  div;
  logic        tx_wr_en;
  logic [1:0]  tx_wr_slot;
  logic [31:0] tx_wr_data;
  logic [1:0]  rx_rd_slot;
  logic [31:0] rx_rd_data;
  logic        busy;
  logic        done;
  logic [15:0] frame_cnt;
  logic        link_clk;
  logic        link_sync_en;
  logic        link_dout;
  logic        link_din;
`ifdef LINK_AUTORUN_EN
  logic        auto_run;
`endif

  int errors = 0;
  int checks = 0;
  int rises  = 0;
  int exp_frames = 0;

  logic [31:0] tb_tx [4];
  logic [31:0] exp_tx_q [$];
  logic [31:0] exp_rx_q [$];

  // Peripheral model state
  logic [31:0] p_in_slot  [4];
  logic [31:0] p_out_slot [4];
  logic [31:0] p_in_sr;
  logic [31:0] p_out_sr;
  logic [1:0]  p_slot;
  logic [4:0]  p_shift;

  serial_link_master dut (
    .clk_board    (clk_board),
    .sys_reset_n  (sys_reset_n),
    .start        (start),
    .div          (div),
    .tx_wr_en     (tx_wr_en),
    .tx_wr_slot   (tx_wr_slot),
    .tx_wr_data   (tx_wr_data),
    .rx_rd_slot   (rx_rd_slot),
    .rx_rd_data   (rx_rd_data),
    .busy         (busy),
    .done         (done),
    .frame_cnt    (frame_cnt),
    .link_clk     (link_clk),
    .link_sync_en (link_sync_en),
    .link_dout    (link_dout),
    .link_din     (link_din)
`ifdef LINK_AUTORUN_EN
    ,
    .auto_run     (auto_run)
`endif
  );

  always #5 clk_board = ~clk_board;

  always @(posedge link_clk) rises++;

  // Peripheral: SYNC commits the input shifter and loads the output shifter; shifts are LSB first.
  always @(posedge link_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      for (int i = 0; i < 4; i++) p_in_slot[i] = '0;
      p_in_sr  = '0;
      p_out_sr = '0;
      p_slot   = '0;
      p_shift  = '0;
      link_din = 1'b0;
    end else if (link_sync_en) begin
      p_in_slot[p_slot] = p_in_sr;
      p_out_sr = p_out_slot[p_slot];
      link_din = p_out_sr[0];
    end else begin
      p_in_sr  = {link_dout, p_in_sr[31:1]};
      p_out_sr = p_out_sr >> 1;
      link_din = p_out_sr[0];
      if (p_shift == 5'd31) p_slot = p_slot + 2'd1;
      p_shift = p_shift + 5'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_tx(input int slot, input logic [31:0] data);
    tx_wr_en   = 1'b1;
    tx_wr_slot = 2'(slot);
    tx_wr_data = data;
    tb_tx[slot] = data;
    @(posedge clk_board); #1;
    tx_wr_en = 1'b0;
  endtask

  // wmode: 0 none, 1 tx write in the start cycle, 2 tx write at cycle 50 of the frame
  task automatic run_frame(input int dv, input int wmode, input int wslot, input logic [31:0] wdata);
    int n;
    int exp_done;
    int r0;
    bit seen;
    exp_done = 266 * (dv + 1) + 1;
    div = 8'(dv);
    for (int i = 0; i < 4; i++) begin
      exp_tx_q.push_back(tb_tx[i]);
      exp_rx_q.push_back(p_out_slot[i]);
    end
    r0 = rises;
    start = 1'b1;
    if (wmode == 1) begin
      tx_wr_en = 1'b1; tx_wr_slot = 2'(wslot); tx_wr_data = wdata; tb_tx[wslot] = wdata;
    end
    @(posedge clk_board); #1;
    start = 1'b0;
    tx_wr_en = 1'b0;
    n = 1;
    check("busy_after_start", busy, 1);
    seen = 0;
    while (!seen && n < exp_done + 40) begin
      if (wmode == 2 && n == 50) begin
        tx_wr_en = 1'b1; tx_wr_slot = 2'(wslot); tx_wr_data = wdata; tb_tx[wslot] = wdata;
      end
      if (n == 100) start = 1'b1;
      @(posedge clk_board); #1;
      n++;
      tx_wr_en = 1'b0;
      start = 1'b0;
      if (done) seen = 1;
    end
    check("done_seen", 32'(seen), 1);
    check("done_cycle", n, exp_done);
    check("busy_at_done", busy, 0);
    check("link_periods", rises - r0, 133);
    exp_frames++;
    check("frame_cnt", frame_cnt, exp_frames);
    @(posedge clk_board); #1;
    check("done_one_cycle", done, 0);
    for (int i = 0; i < 4; i++) begin
      rx_rd_slot = 2'(i);
      #1;
      check($sformatf("periph_in_slot%0d", i), p_in_slot[i], exp_tx_q.pop_front());
      check($sformatf("rx_buf_slot%0d", i), rx_rd_data, exp_rx_q.pop_front());
    end
  endtask

  initial begin
    sys_reset_n = 1'b0;
    start = 1'b0; div = '0; tx_wr_en = 1'b0; tx_wr_slot = '0; tx_wr_data = '0; rx_rd_slot = '0;
`ifdef LINK_AUTORUN_EN
    auto_run = 1'b0;
`endif
    for (int i = 0; i < 4; i++) tb_tx[i] = '0;
    p_out_slot[0] = 32'hA5A5A5A5; p_out_slot[1] = 32'h0000FFFF;
    p_out_slot[2] = 32'h00000001; p_out_slot[3] = 32'hFFFFFFFF;
    repeat (3) @(posedge clk_board);
    @(negedge clk_board) sys_reset_n = 1'b1;

    // Idle without start
    repeat (100) @(posedge clk_board);
    #1;
    check("idle_link_clk", link_clk, 0);
    check("idle_sync_en", link_sync_en, 0);
    check("idle_dout", link_dout, 0);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_frame_cnt", frame_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      rx_rd_slot = 2'(i);
      #1;
      check($sformatf("idle_rx%0d", i), rx_rd_data, 0);
    end

    // Loopback frame at div=0
    write_tx(0, 32'h00000000);
    write_tx(1, 32'hDEADBEEF);
    write_tx(2, 32'h12345678);
    write_tx(3, 32'h80000001);
    run_frame(0, 0, 0, '0);

    // Write during a frame lands in the next frame
    run_frame(1, 2, 1, 32'h11111111);
    // Write in the start cycle: shadow keeps the pre-write word
    run_frame(2, 1, 2, 32'hCAFEF00D);
    p_out_slot[0] = 32'h0F0F0F0F; p_out_slot[1] = 32'h80000000;
    p_out_slot[2] = 32'h7FFFFFFE; p_out_slot[3] = 32'h13579BDF;
    run_frame(0, 0, 0, '0);

    // Asynchronous reset in the middle of window 2's SHIFT
    div = 8'd0;
    rx_rd_slot = 2'd1;
    start = 1'b1;
    @(posedge clk_board); #1;
    start = 1'b0;
    repeat (160) @(posedge clk_board);
    #3;
    sys_reset_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_link_clk", link_clk, 0);
    check("rst_sync_en", link_sync_en, 0);
    check("rst_dout", link_dout, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_rx1", rx_rd_data, 0);
    for (int i = 0; i < 4; i++) tb_tx[i] = '0;
    exp_frames = 0;
    repeat (2) @(posedge clk_board);
    @(negedge clk_board) sys_reset_n = 1'b1;
    @(posedge clk_board); #1;
    write_tx(0, 32'h01020304);
    write_tx(1, 32'hFEEDFACE);
    write_tx(2, 32'h0BADC0DE);
    write_tx(3, 32'h55AA55AA);
    run_frame(0, 0, 0, '0);

`ifdef LINK_AUTORUN_EN
    begin
      int n;
      int last;
      bit seen;
      auto_run = 1'b1;
      div = 8'd3;
      start = 1'b1;
      @(posedge clk_board); #1;
      start = 1'b0;
      n = 1;
      last = 0;
      for (int f = 0; f < 3; f++) begin
        seen = 0;
        while (!seen && n < last + 1100) begin
          @(posedge clk_board); #1;
          n++;
          if (done) seen = 1;
        end
        check("auto_done_seen", 32'(seen), 1);
        check("auto_done_gap", n - last, (f == 0) ? 1065 : 1064);
        last = n;
        exp_frames++;
        check("auto_frame_cnt", frame_cnt, exp_frames);
        check("auto_busy", busy, (f < 2) ? 1 : 0);
        if (f == 1) auto_run = 1'b0;
      end
      @(posedge clk_board); #1;
      check("auto_idle_busy", busy, 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
